// File: rtl/cla4_pkg.sv
// Shared types for the 4-bit carry-lookahead adder slice.
// Optional overflow output: define CLA4_OVF_EN.
package cla4_pkg;

    localparam int CLA_W = 4;

    typedef logic [CLA_W-1:0] cla_word_t;

endpackage

// File: rtl/cla4_reg_adder_if.sv
// Operand/result bus of the registered 4-bit CLA slice.
// Optional overflow output: define CLA4_OVF_EN.
interface cla4_reg_adder_if;
    import cla4_pkg::*;

    logic      in_valid;
    cla_word_t a;
    cla_word_t b;
    logic      ci;
    logic      out_valid;
    cla_word_t s;
    logic      co;
    logic      pg;
    logic      gg;
`ifdef CLA4_OVF_EN
    logic      ovf;

    modport master (
        output in_valid, a, b, ci,
        input  out_valid, s, co, pg, gg, ovf
    );

    modport slave (
        input  in_valid, a, b, ci,
        output out_valid, s, co, pg, gg, ovf
    );
`else
    modport master (
        output in_valid, a, b, ci,
        input  out_valid, s, co, pg, gg
    );

    modport slave (
        input  in_valid, a, b, ci,
        output out_valid, s, co, pg, gg
    );
`endif

endinterface

// File: rtl/cla4_core.sv
// Combinational 4-bit flat carry-lookahead adder with group P/G.
// Optional c3 output for overflow: define CLA4_OVF_EN.
module cla4_core
    import cla4_pkg::*;
(
    input  cla_word_t i_a,
    input  cla_word_t i_b,
    input  logic      i_ci,
    output cla_word_t o_s,
    output logic      o_co,
    output logic      o_pg,
    output logic      o_gg
`ifdef CLA4_OVF_EN
    ,
    output logic      o_c3
`endif
);

    cla_word_t  w_p;
    cla_word_t  w_g;
    logic [4:0] w_c;
    logic       w_pg;
    logic       w_gg;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    assign w_pg = &w_p;
    assign w_gg = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

    // Every carry is a two-level function of p/g/ci; no ripple.
    assign w_c[0] = i_ci;
    assign w_c[1] = w_g[0]
                  | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1]
                  | (w_p[1] & w_g[0])
                  | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2]
                  | (w_p[2] & w_g[1])
                  | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_gg | (w_pg & w_c[0]);

    assign o_s  = w_p ^ w_c[3:0];
    assign o_co = w_c[4];
    assign o_pg = w_pg;
    assign o_gg = w_gg;
`ifdef CLA4_OVF_EN
    assign o_c3 = w_c[3];
`endif

endmodule

// File: rtl/cla4_reg_adder.sv
// 4-bit CLA slice with registered sum/carry/group outputs.
// Optional registered signed overflow: define CLA4_OVF_EN.
module cla4_reg_adder
    import cla4_pkg::*;
#(
    parameter int WIDTH = CLA_W
)(
    input  logic                   clk,
    input  logic                   rst,
    cla4_reg_adder_if.slave        bus
);

    if (WIDTH != CLA_W) begin : g_bad_width
        $error("cla4_reg_adder: WIDTH must be 4");
    end

    cla_word_t w_s;
    logic      w_co;
    logic      w_pg;
    logic      w_gg;

    cla_word_t r_s;
    logic      r_co;
    logic      r_pg;
    logic      r_gg;
    logic      r_out_valid;

`ifdef CLA4_OVF_EN
    logic      w_c3;
    logic      r_ovf;
`endif

    cla4_core u_core (
        .i_a  (bus.a),
        .i_b  (bus.b),
        .i_ci (bus.ci),
        .o_s  (w_s),
        .o_co (w_co),
        .o_pg (w_pg),
        .o_gg (w_gg)
`ifdef CLA4_OVF_EN
        ,
        .o_c3 (w_c3)
`endif
    );

    // Capture results when operands are valid; valid flag tracks in_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_s         <= '0;
            r_co        <= 1'b0;
            r_pg        <= 1'b0;
            r_gg        <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s  <= w_s;
                r_co <= w_co;
                r_pg <= w_pg;
                r_gg <= w_gg;
            end
        end
    end

`ifdef CLA4_OVF_EN
    // Signed overflow is carry into MSB xor carry out of MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (bus.in_valid) begin
            r_ovf <= w_c3 ^ w_co;
        end
    end

    assign bus.ovf = r_ovf;
`endif

    assign bus.out_valid = r_out_valid;
    assign bus.s         = r_s;
    assign bus.co        = r_co;
    assign bus.pg        = r_pg;
    assign bus.gg        = r_gg;

endmodule

// File: tb/tb_cla4_reg_adder.sv
// Randomized + directed bench for cla4_reg_adder against an arithmetic model.
// Overflow output checked when CLA4_OVF_EN is defined.
module tb_cla4_reg_adder;
    import cla4_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: what the outputs should show now.
    logic      m_v   = 1'b0;
    cla_word_t m_s   = '0;
    logic      m_co  = 1'b0;
    logic      m_pg  = 1'b0;
    logic      m_gg  = 1'b0;
    logic      m_ovf = 1'b0;

    cla4_reg_adder_if bus ();

    cla4_reg_adder #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_v));
        chk({tag, ".s"},         32'(bus.s),         32'(m_s));
        chk({tag, ".co"},        32'(bus.co),        32'(m_co));
        chk({tag, ".pg"},        32'(bus.pg),        32'(m_pg));
        chk({tag, ".gg"},        32'(bus.gg),        32'(m_gg));
`ifdef CLA4_OVF_EN
        chk({tag, ".ovf"},       32'(bus.ovf),       32'(m_ovf));
`endif
    endtask

    task automatic model_reset();
        m_v = 1'b0; m_s = '0; m_co = 1'b0;
        m_pg = 1'b0; m_gg = 1'b0; m_ovf = 1'b0;
    endtask

    // Arithmetic view: sum is a+b+ci; group generate means a+b alone
    // overflows 4 bits; group propagate means a and b are complementary.
    task automatic model_step(input logic v, input cla_word_t a,
                              input cla_word_t b, input logic ci);
        int sum;
        m_v = v;
        if (v) begin
            sum   = int'(a) + int'(b) + int'(ci);
            m_s   = cla_word_t'(sum % 16);
            m_co  = (sum >= 16);
            m_gg  = (int'(a) + int'(b) >= 16);
            m_pg  = ((a ^ b) == 4'hF);
            m_ovf = (a[3] == b[3]) && (m_s[3] != a[3]);
        end
    endtask

    task automatic step(input string tag, input logic v,
                        input cla_word_t a, input cla_word_t b,
                        input logic ci);
        @(negedge clk);
        bus.in_valid = v;
        bus.a = a;
        bus.b = b;
        bus.ci = ci;
        @(posedge clk);
        model_step(v, a, b, ci);
        #1;
        chk_all(tag);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.ci = 1'b0;

        // Asynchronous reset: outputs clear before any clock edge.
        #2;
        bus.in_valid = 1'b1;
        bus.a = 4'hF;
        bus.b = 4'hF;
        rst = 1'b1;
        #1;
        model_reset();
        chk_all("rst_async");
        repeat (2) @(posedge clk);
        #1;
        chk_all("rst_held");
        @(negedge clk);
        rst = 1'b0;

        step("f_plus_1", 1'b1, 4'hF, 4'h1, 1'b0);
        step("prop_ci",  1'b1, 4'h5, 4'hA, 1'b1);
        step("3_plus_4", 1'b1, 4'h3, 4'h4, 1'b0);
        step("hold",     1'b0, 4'hF, 4'hF, 1'b0);
        step("ovf_7_1",  1'b1, 4'h7, 4'h1, 1'b0);
        step("neg_ovf",  1'b1, 4'h8, 4'h8, 1'b0);
        step("zero",     1'b1, 4'h0, 4'h0, 1'b0);

        // Reset mid-operation discards the in-flight result.
        step("pre_rst",  1'b1, 4'h9, 4'h9, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = 4'hE;
        bus.b = 4'h3;
        bus.ci = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk_all("rst_mid");
        @(posedge clk);
        #1;
        chk_all("rst_edge");
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 1'b1, 4'hE, 4'h3, 1'b1);

        // Back-to-back random operands, ci fixed at 0 then random.
        for (int i = 0; i < 100; i++) begin
            step("rand_ci0", 1'b1, cla_word_t'($urandom),
                 cla_word_t'($urandom), 1'b0);
        end
        for (int i = 0; i < 100; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0),
                 cla_word_t'($urandom), cla_word_t'($urandom),
                 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
